// File: rtl/key_scan_multi.sv
// Multi-channel key front end: 2-FF sync, press/release debounce, short/long/repeat events per key.
// Registered outputs; no backpressure (free-running, one event evaluation per key per cycle).
module key_scan_multi #(
   parameter int NUM_KEYS     = 4,
   parameter int ACTIVE_LOW   = 1,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int LONG_CYC     = 25000000,
   parameter int REPEAT_CYC   = 5000000,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_short,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_long_pos,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                key_any
);

   typedef enum logic [2:0] {IDLE, P_DB, PRESSED, LONG, R_DB} state_t;

   localparam logic             INACT = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] DB    = CNT_W'(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] LG1   = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] RP1   = CNT_W'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [NUM_KEYS-1:0] sync1_q, sync2_q, press;
   logic [NUM_KEYS-1:0] short_nx, lpos_nx, rep_nx;
   logic                key_any_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= {NUM_KEYS{INACT}};
         sync2_q <= {NUM_KEYS{INACT}};
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

   assign press = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      state_t           state_q, state_d;
      logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d, rcnt_q, rcnt_d;
      logic             orig_long_q, orig_long_d;
      logic             st_q, st_d, long_q, long_d;
      logic             short_q, short_d, lpos_q, lpos_d, rep_q, rep_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            orig_long_q <= 1'b0;
            st_q        <= 1'b0;
            long_q      <= 1'b0;
            short_q     <= 1'b0;
            lpos_q      <= 1'b0;
            rep_q       <= 1'b0;
         end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            orig_long_q <= orig_long_d;
            st_q        <= st_d;
            long_q      <= long_d;
            short_q     <= short_d;
            lpos_q      <= lpos_d;
            rep_q       <= rep_d;
         end
      end

      always_comb begin
         state_d     = state_q;
         dcnt_d      = dcnt_q;
         hcnt_d      = hcnt_q;
         rcnt_d      = rcnt_q;
         orig_long_d = orig_long_q;
         st_d        = st_q;
         long_d      = long_q;
         short_d     = 1'b0;
         lpos_d      = 1'b0;
         rep_d       = 1'b0;
         case (state_q)
            IDLE: begin
               dcnt_d = '0;
               hcnt_d = '0;
               rcnt_d = '0;
               if (press[k]) begin
                  state_d = P_DB;
                  dcnt_d  = ONE;
               end
            end
            P_DB: begin
               if (!press[k]) begin
                  state_d = IDLE;
                  dcnt_d  = '0;
               end else if (dcnt_q == DB) begin
                  state_d = PRESSED;
                  st_d    = 1'b1;
                  hcnt_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + ONE;
               end
            end
            PRESSED: begin
               // hold time counts every cycle spent here, saturating one short of the long event
               if (hcnt_q != LG1) hcnt_d = hcnt_q + ONE;
               if (!press[k]) begin
                  state_d     = R_DB;
                  dcnt_d      = ONE;
                  orig_long_d = 1'b0;
               end else if (hcnt_q == LG1) begin
                  state_d = LONG;
                  long_d  = 1'b1;
                  lpos_d  = 1'b1;
                  rcnt_d  = '0;
               end
            end
            LONG: begin
               if (rcnt_q != RP1) rcnt_d = rcnt_q + ONE;
               if (!press[k]) begin
                  state_d     = R_DB;
                  dcnt_d      = ONE;
                  orig_long_d = 1'b1;
               end else if ((REPEAT_CYC != 0) && (rcnt_q == RP1)) begin
                  rep_d  = 1'b1;
                  rcnt_d = '0;
               end
            end
            R_DB: begin
               if (press[k]) begin
                  state_d = orig_long_q ? LONG : PRESSED;
               end else if (dcnt_q == DB) begin
                  state_d = IDLE;
                  st_d    = 1'b0;
                  long_d  = 1'b0;
                  short_d = ~orig_long_q;
                  dcnt_d  = '0;
                  hcnt_d  = '0;
                  rcnt_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      assign short_nx[k]     = short_d;
      assign lpos_nx[k]      = lpos_d;
      assign rep_nx[k]       = rep_d;
      assign key_state[k]    = st_q;
      assign key_long[k]     = long_q;
      assign key_short[k]    = short_q;
      assign key_long_pos[k] = lpos_q;
      assign key_repeat[k]   = rep_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) key_any_q <= 1'b0;
      else        key_any_q <= |(short_nx | lpos_nx | rep_nx);
   end

   assign key_any = key_any_q;

endmodule

// File: tb/tb_key_scan_multi.sv
// Bench for key_scan_multi: directed scenarios plus random key activity against a sample-history model.
module tb_key_scan_multi;
   localparam int DB = 4;
   localparam int LG = 20;
   localparam int RP = 8;

   logic       clk;
   logic       rst_n;
   logic [1:0] key_in;
   logic [1:0] key_state, key_short, key_long, key_long_pos, key_repeat;
   logic       key_any;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   key_scan_multi #(
      .NUM_KEYS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYC(DB),
      .LONG_CYC(LG), .REPEAT_CYC(RP), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in),
      .key_state(key_state), .key_short(key_short), .key_long(key_long),
      .key_long_pos(key_long_pos), .key_repeat(key_repeat), .key_any(key_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: pin delay line, run lengths of press/release samples, time spent held
   bit d1[2], d2[2], prev_p[2], phase[2], lng[2];
   int ones[2], zeros[2], tp[2], tl[2];
   bit m_state[2], m_long[2], m_short[2], m_lpos[2], m_rep[2];

   int rise_n[2], fall_n[2], short_n[2], lpos_n[2], rep_n[2];
   int rise_c[2], fall_c[2], lpos_c[2], rep1_c[2];
   bit prev_ks[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         d1[k] = 1; d2[k] = 1; prev_p[k] = 0; phase[k] = 0; lng[k] = 0;
         ones[k] = 0; zeros[k] = 0; tp[k] = 0; tl[k] = 0;
         m_state[k] = 0; m_long[k] = 0; m_short[k] = 0; m_lpos[k] = 0; m_rep[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit p;
         p = !d2[k];
         d2[k] = d1[k];
         d1[k] = key_in[k];
         m_short[k] = 0; m_lpos[k] = 0; m_rep[k] = 0;
         if (!phase[k]) begin
            ones[k] = p ? ones[k] + 1 : 0;
            if (ones[k] == DB + 1) begin
               phase[k] = 1; m_state[k] = 1;
               zeros[k] = 0; tp[k] = 0; tl[k] = 0; lng[k] = 0;
            end
         end else begin
            zeros[k] = p ? 0 : zeros[k] + 1;
            if (zeros[k] == DB + 1) begin
               phase[k] = 0; m_short[k] = !lng[k];
               m_state[k] = 0; m_long[k] = 0; ones[k] = 0;
            end else if (prev_p[k]) begin
               if (!lng[k]) begin
                  tp[k]++;
                  if (p && tp[k] >= LG) begin lng[k] = 1; m_long[k] = 1; m_lpos[k] = 1; end
               end else begin
                  tl[k]++;
                  if (p && RP != 0 && tl[k] >= RP) begin m_rep[k] = 1; tl[k] = 0; end
               end
            end
         end
         prev_p[k] = p;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_all();
      bit any_exp;
      any_exp = 0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("key_state[%0d]", k),    32'(key_state[k]),    32'(m_state[k]));
         chk($sformatf("key_long[%0d]", k),     32'(key_long[k]),     32'(m_long[k]));
         chk($sformatf("key_short[%0d]", k),    32'(key_short[k]),    32'(m_short[k]));
         chk($sformatf("key_long_pos[%0d]", k), 32'(key_long_pos[k]), 32'(m_lpos[k]));
         chk($sformatf("key_repeat[%0d]", k),   32'(key_repeat[k]),   32'(m_rep[k]));
         any_exp = any_exp | m_short[k] | m_lpos[k] | m_rep[k];
      end
      chk("key_any", 32'(key_any), 32'(any_exp));
   endtask

   task automatic clear_stats();
      for (int k = 0; k < 2; k++) begin
         rise_n[k] = 0; fall_n[k] = 0; short_n[k] = 0; lpos_n[k] = 0; rep_n[k] = 0;
         rise_c[k] = -1; fall_c[k] = -1; lpos_c[k] = -1; rep1_c[k] = -1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (key_state[k] === 1'b1 && !prev_ks[k]) begin rise_n[k]++; rise_c[k] = cyc; end
         if (key_state[k] === 1'b0 && prev_ks[k])  begin fall_n[k]++; fall_c[k] = cyc; end
         if (key_short[k] === 1'b1) short_n[k]++;
         if (key_long_pos[k] === 1'b1) begin lpos_n[k]++; lpos_c[k] = cyc; end
         if (key_repeat[k] === 1'b1) begin
            rep_n[k]++;
            if (rep1_c[k] < 0) rep1_c[k] = cyc;
         end
         prev_ks[k] = (key_state[k] === 1'b1);
      end
   endtask

   task automatic hold(input logic [1:0] v, input int n);
      key_in = v;
      repeat (n) step();
   endtask

   task automatic do_reset(input int n);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      for (int k = 0; k < 2; k++) prev_ks[k] = 0;
      repeat (n) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int rem[2];
      rst_n  = 1'b0;
      key_in = 2'b11;
      model_reset();
      clear_stats();
      for (int k = 0; k < 2; k++) prev_ks[k] = 0;
      repeat (3) @(posedge clk);
      #1;
      check_all();
      #3 rst_n = 1'b1;
      hold(2'b11, 5);

      // glitch shorter than the debounce window
      clear_stats();
      hold(2'b10, 3);
      hold(2'b11, 15);
      chk("glitch_rise", rise_n[0], 0);
      chk("glitch_pulses", short_n[0] + lpos_n[0] + rep_n[0], 0);

      // short press
      clear_stats();
      hold(2'b10, 12);
      hold(2'b11, 15);
      chk("short_cnt", short_n[0], 1);
      chk("short_nolong", lpos_n[0], 0);
      chk("short_width", fall_c[0] - rise_c[0], 12);

      // long press with auto-repeat
      clear_stats();
      hold(2'b10, 50);
      hold(2'b11, 15);
      chk("long_lpos_cnt", lpos_n[0], 1);
      chk("long_lpos_lat", lpos_c[0] - rise_c[0], LG);
      chk("long_rep_cnt", rep_n[0], 3);
      chk("long_rep_lat", rep1_c[0] - lpos_c[0], RP);
      chk("long_noshort", short_n[0], 0);
      chk("long_fall", fall_n[0], 1);

      // release bounce while pressed: two cycles in R_DB delay the long event by two
      clear_stats();
      hold(2'b10, 10);
      hold(2'b11, 2);
      hold(2'b10, 40);
      hold(2'b11, 15);
      chk("bounce_rise", rise_n[0], 1);
      chk("bounce_fall", fall_n[0], 1);
      chk("bounce_noshort", short_n[0], 0);
      chk("bounce_lpos_lat", lpos_c[0] - rise_c[0], LG + 2);

      // both keys together, key0 short, key1 long
      clear_stats();
      hold(2'b00, 12);
      hold(2'b01, 28);
      hold(2'b11, 15);
      chk("conc_short0", short_n[0], 1);
      chk("conc_short1", short_n[1], 0);
      chk("conc_lpos1", lpos_n[1], 1);
      chk("conc_same_rise", rise_c[1] - rise_c[0], 0);

      // reset while key1 is in LONG, key re-debounces as a new press
      hold(2'b01, 35);
      do_reset(2);
      clear_stats();
      hold(2'b01, 15);
      chk("rst_rise1", rise_n[1], 1);
      chk("rst_noshort1", short_n[1], 0);
      hold(2'b11, 15);

      // random activity on both keys, run lengths spanning glitch, short and long holds
      rem[0] = 0; rem[1] = 0;
      for (int i = 0; i < 1600; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (rem[k] == 0) begin
               key_in[k] = ~key_in[k];
               case ($urandom_range(0, 3))
                  0:       rem[k] = $urandom_range(1, 4);
                  1:       rem[k] = $urandom_range(5, 15);
                  default: rem[k] = $urandom_range(16, 60);
               endcase
            end
            rem[k]--;
         end
         step();
         if (i == 800) do_reset($urandom_range(1, 3));
      end
      hold(2'b11, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
